// File: rtl/apb_reg_responder.sv
// APB completer backed by a small bank of 32-bit registers.
// Supports byte strobes, a fixed number of wait states and an error response
// for misaligned or out-of-range addresses. Register contents are exported flat on reg_q.
module apb_reg_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  input  logic [DATA_W/8-1:0]          PSTRB,
  output logic                         PREADY,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

  localparam int unsigned NumLanes = DATA_W / 8;
  localparam int unsigned IdxW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // First byte address past the register bank.
  localparam logic [ADDR_W-1:0] AddrLimit = ADDR_W'(4 * NUM_REGS);
  // WAIT_STATES == 0 skips the wait state entirely, so the load value is unused there.
  localparam logic [3:0] CntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [NumLanes-1:0] strb_q, strb_d;

  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                setup;
  logic                setup_err;
  logic [IdxW-1:0]     setup_idx;
  logic                commit;

  // Decode of the live bus, used only at the setup phase.
  assign setup     = PSEL && !PENABLE;
  assign setup_err = (PADDR[1:0] != 2'b00) || (PADDR >= AddrLimit);
  assign setup_idx = PADDR[IdxW+1:2];

  // Write lands on the edge leaving READY, using data present at that edge.
  assign commit = (state_q == StReady) && PSEL && PENABLE && write_q && !err_q;

  // Next-state and transfer capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    strb_d  = strb_q;
    unique case (state_q)
      StIdle: begin
        // PENABLE without a preceding setup phase is ignored here.
        if (setup) begin
          idx_d   = setup_idx;
          write_d = PWRITE;
          err_d   = setup_err;
          strb_d  = PSTRB;
          cnt_d   = CntInit;
          state_d = (WAIT_STATES == 0) ? StReady : StWait;
        end
      end
      StWait: begin
        if (!PSEL) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StReady;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StReady: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Response registers: loaded on entry to READY, zero elsewhere.
  // The *_d captures equal the live decode when entering READY straight from IDLE.
  always_comb begin
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (state_d == StReady) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      if (!write_d && !err_d) begin
        prdata_d = regs_q[idx_d];
      end
    end
  end

  // FSM and captured transfer attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
      strb_q  <= strb_d;
    end
  end

  // Registered APB response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Register bank with per-lane write enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (commit) begin
      for (int l = 0; l < NumLanes; l++) begin
        if (strb_q[l]) begin
          regs_q[idx_q][8*l +: 8] <= PWDATA[8*l +: 8];
        end
      end
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign reg_q[DATA_W*k +: DATA_W] = regs_q[k];
  end

endmodule

// File: tb/tb_apb_reg_responder.sv
// Bench for apb_reg_responder: three instances (WAIT_STATES 1, 3, 0) driven by directed
// transfers; expected responses go into a scoreboard that a negedge monitor drains.
module tb_apb_reg_responder;

  localparam int NI = 3;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         psel    [NI];
  logic         penable [NI];
  logic         pwrite  [NI];
  logic [31:0]  paddr   [NI];
  logic [31:0]  pwdata  [NI];
  logic [3:0]   pstrb   [NI];
  logic         pready  [NI];
  logic         pslverr [NI];
  logic [31:0]  prdata  [NI];
  logic [127:0] regq    [NI];

  logic [31:0]  model [NI][4];
  exp_t         sb[$];
  int unsigned  cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_reg_responder #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .NUM_REGS   (4),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .PSEL   (psel[g]),
      .PENABLE(penable[g]),
      .PWRITE (pwrite[g]),
      .PADDR  (paddr[g]),
      .PWDATA (pwdata[g]),
      .PSTRB  (pstrb[g]),
      .PREADY (pready[g]),
      .PRDATA (prdata[g]),
      .PSLVERR(pslverr[g]),
      .reg_q  (regq[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_regs(string name, int i);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s inst%0d reg%0d", name, i, k), regq[i][32*k +: 32], model[i][k]);
    end
  endfunction

  function automatic void chk_all_zero(string name);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s pready%0d", name, i), 32'(pready[i]), 32'd0);
      chk($sformatf("%s prdata%0d", name, i), prdata[i], 32'd0);
      chk($sformatf("%s pslverr%0d", name, i), 32'(pslverr[i]), 32'd0);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s regq%0d.%0d", name, i, k), regq[i][32*k +: 32], 32'd0);
      end
    end
  endfunction

  function automatic void idle_bus(int i);
    psel[i]    = 1'b0;
    penable[i] = 1'b0;
    pwrite[i]  = 1'b0;
    paddr[i]   = '0;
    pwdata[i]  = '0;
    pstrb[i]   = '0;
  endfunction

  // Monitor: every PREADY pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (pready[i] !== 1'b0) begin
          if (sb.size() == 0) begin
            chk($sformatf("unexpected pready inst%0d", i), 32'(pready[i]), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("resp instance", 32'(i), 32'(e.inst));
            chk($sformatf("prdata inst%0d", i), prdata[i], e.rdata);
            chk($sformatf("pslverr inst%0d", i), 32'(pslverr[i]), 32'(e.err));
            chk($sformatf("pready cycle inst%0d", i), cyc, e.cyc);
          end
        end
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the completing edge so the
  // next call starts its setup phase in the cycle right after READY.
  // Address, direction and strobe are scrambled after setup and write data is junk
  // during setup, since the completer must sample them only at their own edges.
  task automatic xfer(input int i, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] erd, input bit eerr);
    exp_t e;
    int   n;
    e.inst  = i;
    e.rdata = erd;
    e.err   = eerr;
    e.cyc   = cyc + 1 + ws_of(i);
    sb.push_back(e);
    psel[i]    = 1'b1;
    penable[i] = 1'b0;
    pwrite[i]  = wr;
    paddr[i]   = addr;
    pstrb[i]   = strb;
    pwdata[i]  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    penable[i] = 1'b1;
    pwrite[i]  = ~wr;
    paddr[i]   = ~addr;
    pstrb[i]   = ~strb;
    pwdata[i]  = data;
    n = 0;
    while (pready[i] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (pready[i] !== 1'b1) chk($sformatf("timeout inst%0d", i), 32'd0, 32'd1);
    @(posedge clk); #1;
    idle_bus(i);
    if (wr && !eerr) begin
      for (int l = 0; l < 4; l++) begin
        if (strb[l]) model[i][addr[3:2]][8*l +: 8] = data[8*l +: 8];
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      idle_bus(i);
      for (int k = 0; k < 4; k++) model[i][k] = '0;
    end

    // Reset held with random bus activity.
    rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        psel[i]    = 1'($urandom_range(0, 1));
        penable[i] = 1'($urandom_range(0, 1));
        pwrite[i]  = 1'($urandom_range(0, 1));
        paddr[i]   = $urandom_range(0, 15);
        pwdata[i]  = $urandom;
        pstrb[i]   = 4'($urandom_range(0, 15));
      end
    end
    chk_all_zero("in reset");
    for (int i = 0; i < NI; i++) idle_bus(i);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0000, 1'b0);

    // WAIT_STATES=1 write/read.
    xfer(0, 1'b1, 32'h0, 32'h0000_0006, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0006, 1'b0);
    chk_regs("after write 0x0", 0);
    xfer(0, 1'b1, 32'hC, 32'h5665_726F, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'hC, 32'h0, 4'h0, 32'h5665_726F, 1'b0);
    chk_regs("after write 0xC", 0);

    // Byte strobes, including a zero-strobe no-op write.
    xfer(0, 1'b1, 32'h4, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h4, 32'h0000_3C00, 4'h2, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'hA5A5_3CA5, 1'b0);
    xfer(0, 1'b1, 32'h8, 32'h1122_3344, 4'h5, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0006, 1'b0);
    chk_regs("after strobes", 0);

    // Error responses.
    xfer(0, 1'b1, 32'h10, 32'h4465_7262, 4'hF, 32'h0, 1'b1);
    chk_regs("after error write", 0);
    xfer(0, 1'b0, 32'h6, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 32'h0022_0044, 1'b0);

    // WAIT_STATES=3: abort by dropping PSEL in WAIT.
    xfer(1, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h4; pstrb[1] = 4'hF; pwdata[1] = 32'h1234_5678;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    idle_bus(1);
    repeat (6) @(posedge clk);
    #1;
    chk("abort no pready", 32'(pready[1]), 32'd0);
    chk_regs("after abort", 1);
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

    // Reset during WAIT after a completed write.
    xfer(1, 1'b1, 32'h0, 32'h0000_1234, 4'hF, 32'h0, 1'b0);
    chk_regs("before reset", 1);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h0; pstrb[1] = 4'hF; pwdata[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 4; k++) model[i][k] = '0;
    end
    chk_all_zero("mid-transfer reset");
    idle_bus(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0000, 1'b0);

    // WAIT_STATES=0 back-to-back, new setup right after each READY.
    xfer(2, 1'b1, 32'h0, 32'h1111_0001, 4'hF, 32'h0, 1'b0);
    xfer(2, 1'b1, 32'h4, 32'h2222_0002, 4'hF, 32'h0, 1'b0);
    xfer(2, 1'b1, 32'h8, 32'h3333_0003, 4'hF, 32'h0, 1'b0);
    xfer(2, 1'b1, 32'hC, 32'h4444_0004, 4'hF, 32'h0, 1'b0);
    xfer(2, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_0001, 1'b0);
    xfer(2, 1'b0, 32'h4, 32'h0, 4'h0, 32'h2222_0002, 1'b0);
    xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, 32'h3333_0003, 1'b0);
    xfer(2, 1'b0, 32'hC, 32'h0, 4'h0, 32'h4444_0004, 1'b0);
    xfer(2, 1'b1, 32'hC, 32'h0000_0055, 4'h1, 32'h0, 1'b0);
    xfer(2, 1'b0, 32'hC, 32'h0, 4'h0, 32'h4444_0055, 1'b0);
    chk_regs("after back-to-back", 2);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
